// File: rtl/lime_control_fsm.sv
// Multi-cycle control FSM for the 16-bit Lime processor: decodes the IR control field,
// sequences fetch/decode/execute/memory/writeback strobes, counts retired instructions.
module lime_control_fsm #(
  parameter logic [6:0] OP_HALT = 7'h7F,
  parameter logic [2:0] ALU_ADD = 3'b000,
  parameter logic [2:0] ALU_SUB = 3'b001
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [6:0]  opcode,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        IorD,
  output logic        memR,
  output logic        memW,
  output logic        mem2reg,
  output logic        regWrite,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUOp,
  output logic        PCSrc,
  output logic        branch,
  output logic [1:0]  branchType,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] retired,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_START, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR,
    S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic        illegal_q, illegal_d;
  logic [15:0] retired_q, retired_d;
  logic        retire;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_START;
      illegal_q <= 1'b0;
      retired_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  // Memory handshake: a read/write strobe is held steady from the first cycle of the
  // access until the cycle in which mem_ready is seen high; that cycle completes it.
  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    retire     = 1'b0;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    IorD       = 1'b0;
    memR       = 1'b0;
    memW       = 1'b0;
    mem2reg    = 1'b0;
    regWrite   = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = ALU_ADD;
    PCSrc      = 1'b0;
    branch     = 1'b0;
    branchType = 2'b00;
    halted     = 1'b0;
    case (state_q)
      S_START: state_d = S_FETCH;
      S_FETCH: begin
        memR    = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = mem_ready;
        IRWrite = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while the class is decoded.
        ALUSrcB = 2'b10;
        case (opcode[6:4])
          3'b000:         state_d = S_EXEC_R;
          3'b001:         state_d = S_EXEC_I;
          3'b010, 3'b011: state_d = S_MEM_ADDR;
          3'b100:         state_d = S_BRANCH;
          3'b101:         state_d = S_JUMP;
          default: begin
            state_d   = S_HALT;
            illegal_d = (opcode != OP_HALT);
          end
        endcase
      end
      S_EXEC_R: begin
        ALUSrcA = 2'b01;
        ALUOp   = opcode[2:0];
        state_d = S_ALU_WB;
      end
      S_EXEC_I: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        ALUOp   = opcode[2:0];
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        regWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        state_d = (opcode[6:4] == 3'b010) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        memR = 1'b1;
        IorD = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        regWrite = 1'b1;
        mem2reg  = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_WRITE: begin
        memW = 1'b1;
        IorD = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b01;
        ALUOp      = ALU_SUB;
        branch     = 1'b1;
        branchType = opcode[1:0];
        PCSrc      = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: state_d = S_START;
    endcase
    retired_d = retire ? retired_q + 16'd1 : retired_q;
  end

  assign illegal   = illegal_q;
  assign retired   = retired_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lime_control_fsm.sv
// Bench for lime_control_fsm: directed latency table, stall/halt/reset sequences and
// random instruction streams checked cycle by cycle against per-class step scripts.
module tb_lime_control_fsm;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [6:0]  opcode = 7'h00;
  logic        mem_ready = 1'b0;
  logic        PCWrite, IRWrite, IorD, memR, memW, mem2reg, regWrite;
  logic [1:0]  ALUSrcA, ALUSrcB, branchType;
  logic [2:0]  ALUOp;
  logic        PCSrc, branch, halted, illegal;
  logic [15:0] retired;
  logic [3:0]  dbg_state;

  lime_control_fsm dut (
    .CLK(CLK), .RESET_N(RESET_N), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .memR(memR), .memW(memW),
    .mem2reg(mem2reg), .regWrite(regWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSrc(PCSrc), .branch(branch), .branchType(branchType),
    .halted(halted), .illegal(illegal), .retired(retired), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  localparam int K_START = 0, K_F = 1, K_D = 2, K_EXR = 3, K_EXI = 4, K_AWB = 5, K_MA = 6,
                 K_MR = 7, K_MWB = 8, K_MW = 9, K_BR = 10, K_JP = 11, K_HALT = 12;

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_ret = 16'd0;
  logic        exp_ill = 1'b0;
  int          script[$];
  logic [19:0] exp_q[$];

  wire [19:0] got_vec = {PCWrite, IRWrite, IorD, memR, memW, mem2reg, regWrite,
                         ALUSrcA, ALUSrcB, ALUOp, PCSrc, branch, branchType, halted, illegal};

  // Expected strobe bundle for one step of an instruction's script.
  function automatic logic [19:0] exp_vec(int kind, logic [6:0] op, logic rdy, logic ill);
    logic pcw, irw, iord, rd, wr, m2r, rw, pcs, br, hl, il;
    logic [1:0] sa, sb, bt;
    logic [2:0] aop;
    {pcw, irw, iord, rd, wr, m2r, rw, pcs, br, hl, il} = '0;
    sa = 2'b00; sb = 2'b00; bt = 2'b00; aop = 3'b000;
    case (kind)
      K_F:    begin rd = 1; sb = 2'b01; pcw = rdy; irw = rdy; end
      K_D:    sb = 2'b10;
      K_EXR:  begin sa = 2'b01; aop = op[2:0]; end
      K_EXI:  begin sa = 2'b01; sb = 2'b10; aop = op[2:0]; end
      K_AWB:  rw = 1;
      K_MA:   begin sa = 2'b01; sb = 2'b10; end
      K_MR:   begin rd = 1; iord = 1; end
      K_MWB:  begin rw = 1; m2r = 1; end
      K_MW:   begin wr = 1; iord = 1; end
      K_BR:   begin sa = 2'b01; aop = 3'b001; br = 1; bt = op[1:0]; pcs = 1; end
      K_JP:   begin pcw = 1; pcs = 1; end
      K_HALT: begin hl = 1; il = ill; end
      default: ;
    endcase
    return {pcw, irw, iord, rd, wr, m2r, rw, sa, sb, aop, pcs, br, bt, hl, il};
  endfunction

  task automatic check(input string name, input logic [19:0] got, input logic [19:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // scoreboard: one queued expectation popped and compared per sampled cycle
  task automatic sample(input string name);
    logic [19:0] e;
    e = exp_q.pop_front();
    check(name, got_vec, e);
    check({name, "_retired"}, {4'b0, retired}, {4'b0, exp_ret});
  endtask

  task automatic make_script(input logic [6:0] op);
    script = {K_F, K_D};
    case (op[6:4])
      3'd0: begin script.push_back(K_EXR); script.push_back(K_AWB); end
      3'd1: begin script.push_back(K_EXI); script.push_back(K_AWB); end
      3'd2: begin script.push_back(K_MA); script.push_back(K_MR); script.push_back(K_MWB); end
      3'd3: begin script.push_back(K_MA); script.push_back(K_MW); end
      3'd4: script.push_back(K_BR);
      3'd5: script.push_back(K_JP);
      default: script.push_back(K_HALT);
    endcase
  endtask

  // driver: apply inputs after the edge, compare at negedge, advance past next posedge
  task automatic step(input int kind, input logic [6:0] op, input logic rdy, output logic adv);
    opcode = op;
    mem_ready = rdy;
    exp_q.push_back(exp_vec(kind, op, rdy, exp_ill));
    @(negedge CLK);
    sample($sformatf("k%0d_op%h", kind, op));
    adv = !((kind == K_F || kind == K_MR || kind == K_MW) && !rdy);
    @(posedge CLK);
    #1;
  endtask

  // mode 0: memory always ready; 1: random stalls; 2: exactly 3 stall cycles in MEM_READ
  function automatic logic pick_rdy(int mode, int kind, int stalls);
    if (mode == 0) return 1'b1;
    if (mode == 2) return (kind == K_MR) ? (stalls >= 3) : 1'b1;
    if (stalls >= 20) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  // Runs one instruction; stops on entering HALT (the caller then holds it).
  task automatic run_instr(input logic [6:0] op, input int mode, output int cycles);
    logic adv, done;
    int stalls;
    make_script(op);
    cycles = 0;
    done = 1'b0;
    for (int i = 0; i < script.size() && !done; i++) begin
      if (script[i] == K_HALT) begin
        exp_ill = (op != 7'h7F);
        done = 1'b1;
      end else begin
        stalls = 0;
        do begin
          step(script[i], op, pick_rdy(mode, script[i], stalls), adv);
          cycles++;
          stalls++;
        end while (!adv);
      end
    end
    if (!done) exp_ret++;
  endtask

  task automatic run_halt(input logic [6:0] op, input int n);
    logic adv;
    for (int i = 0; i < n; i++) step(K_HALT, op, 1'($urandom_range(0, 1)), adv);
  endtask

  task automatic release_and_start();
    repeat (2) @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    mem_ready = 1'b1;
    exp_q.push_back(exp_vec(K_START, 7'h00, 1'b1, 1'b0));
    @(negedge CLK);
    sample("start");
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    exp_ret = 16'd0;
    exp_ill = 1'b0;
    release_and_start();
  endtask

  typedef struct {
    logic [6:0] op;
    int         lat;
  } vec_t;

  initial begin
    vec_t tbl[8];
    int   cyc;
    logic adv;
    logic [6:0] op;

    tbl[0] = '{7'h01, 4}; tbl[1] = '{7'h1A, 4}; tbl[2] = '{7'h20, 5}; tbl[3] = '{7'h37, 4};
    tbl[4] = '{7'h42, 3}; tbl[5] = '{7'h43, 3}; tbl[6] = '{7'h51, 3}; tbl[7] = '{7'h07, 4};

    do_reset();

    foreach (tbl[i]) begin
      run_instr(tbl[i].op, 0, cyc);
      check($sformatf("latency_op%h", tbl[i].op), 20'(cyc), 20'(tbl[i].lat));
    end

    run_instr(7'h20, 2, cyc);
    check("load_stall_latency", 20'(cyc), 20'd8);

    for (int n = 0; n < 200; n++) begin
      op = {3'($urandom_range(0, 5)), 4'($urandom_range(0, 15))};
      run_instr(op, 1, cyc);
    end

    run_instr(7'h60, 1, cyc);
    run_halt(7'h60, 100);
    do_reset();
    run_instr(7'h7F, 1, cyc);
    run_halt(7'h7F, 10);
    do_reset();
    run_instr(7'h75, 0, cyc);
    run_halt(7'h75, 5);
    do_reset();

    // reset pulsed in the middle of a stalled store
    run_instr(7'h05, 0, cyc);
    run_instr(7'h5E, 0, cyc);
    step(K_F, 7'h30, 1'b1, adv);
    step(K_D, 7'h30, 1'b1, adv);
    step(K_MA, 7'h30, 1'b1, adv);
    step(K_MW, 7'h30, 1'b0, adv);
    opcode = 7'h30;
    mem_ready = 1'b0;
    exp_q.push_back(exp_vec(K_MW, 7'h30, 1'b0, 1'b0));
    @(negedge CLK);
    sample("store_stalled");
    #2;
    RESET_N = 1'b0;
    exp_ret = 16'd0;
    #1;
    exp_q.push_back(20'd0);
    sample("async_reset");
    release_and_start();
    run_instr(7'h31, 0, cyc);
    check("store_after_reset", 20'(cyc), 20'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
